// File: rtl/acc_requant.sv
// rtl/acc_requant.sv - 3-stage requantizer: scale, rounding shift, optional ReLU, zero-point, saturate.
// Optional ReLU before the zero-point add is enabled by defining REQUANT_RELU_EN.
module acc_requant #(
    parameter int ACC_WIDTH   = 16,
    parameter int OUT_WIDTH   = 4,
    parameter int SCALE_WIDTH = 8,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [SCALE_WIDTH-1:0] cfg_scale,
    input  logic [SHIFT_WIDTH-1:0] cfg_shift,
    input  logic [OUT_WIDTH-1:0]   cfg_zp,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ACC_WIDTH-1:0]   in_acc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic [15:0]            sat_count
);

    localparam int P_W = ACC_WIDTH + SCALE_WIDTH + 1;
    localparam int R_W = P_W + 1;
    localparam int T_W = R_W + 1;
    localparam logic signed [T_W-1:0] OUT_MAX = T_W'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [T_W-1:0] OUT_MIN = T_W'(-(2 ** (OUT_WIDTH - 1)));

    logic                          v1, v2, v3;
    logic                          load1, load2, load3;
    logic                          accept;

    logic signed [P_W-1:0]         acc_ext, scale_ext, p_next;
    logic signed [P_W-1:0]         p1;
    logic        [SHIFT_WIDTH-1:0] sh1;
    logic        [OUT_WIDTH-1:0]   zp1, zp2;

    logic signed [R_W-1:0]         p_wide, rnd, r_next;
    logic signed [R_W-1:0]         r2;

    logic signed [R_W-1:0]         r_act;
    logic signed [T_W-1:0]         t_sum;
    logic        [OUT_WIDTH-1:0]   out_next;
    logic                          clamped;

    // A stage advances when it is empty or its successor advances (bubble collapse).
    assign load3     = !v3 || out_ready;
    assign load2     = !v2 || load3;
    assign load1     = !v1 || load2;
    assign in_ready  = !reset && load1;
    assign accept    = in_valid && in_ready;
    assign out_valid = v3;

    // Stage 1: signed accumulator times zero-extended unsigned scale.
    always_comb begin
        acc_ext   = {{(P_W - ACC_WIDTH){in_acc[ACC_WIDTH-1]}}, in_acc};
        scale_ext = {{(P_W - SCALE_WIDTH){1'b0}}, cfg_scale};
        p_next    = acc_ext * scale_ext;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1  <= 1'b0;
            p1  <= '0;
            sh1 <= '0;
            zp1 <= '0;
        end else if (load1) begin
            v1 <= accept;
            if (accept) begin
                p1  <= p_next;
                sh1 <= cfg_shift;
                zp1 <= cfg_zp;
            end
        end
    end

    // Stage 2: round-half-up arithmetic shift, one bit wider than p so the bias cannot overflow.
    always_comb begin
        p_wide = {p1[P_W-1], p1};
        rnd    = '0;
        r_next = p_wide;
        if (sh1 == '0) begin
            r_next = p_wide;
        end else if (32'(sh1) >= R_W) begin
            r_next = {R_W{p1[P_W-1]}};
        end else begin
            rnd    = R_W'(1) << (sh1 - 1'b1);
            r_next = (p_wide + rnd) >>> sh1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v2  <= 1'b0;
            r2  <= '0;
            zp2 <= '0;
        end else if (load2) begin
            v2 <= v1;
            if (v1) begin
                r2  <= r_next;
                zp2 <= zp1;
            end
        end
    end

    // Stage 3: optional ReLU, zero-point add, saturate to the signed output range.
    always_comb begin
`ifdef REQUANT_RELU_EN
        r_act = r2[R_W-1] ? '0 : r2;
`else
        r_act = r2;
`endif
        t_sum    = {r_act[R_W-1], r_act} + {{(T_W - OUT_WIDTH){zp2[OUT_WIDTH-1]}}, zp2};
        clamped  = 1'b0;
        out_next = t_sum[OUT_WIDTH-1:0];
        if (t_sum > OUT_MAX) begin
            clamped  = 1'b1;
            out_next = OUT_MAX[OUT_WIDTH-1:0];
        end else if (t_sum < OUT_MIN) begin
            clamped  = 1'b1;
            out_next = OUT_MIN[OUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v3        <= 1'b0;
            out_data  <= '0;
            sat_count <= '0;
        end else if (load3) begin
            v3 <= v2;
            if (v2) begin
                out_data <= out_next;
                if (clamped && (sat_count != 16'hFFFF)) begin
                    sat_count <= sat_count + 16'd1;
                end
            end
        end
    end

endmodule
